// File: rtl/culsans_ace_tagger.sv
// culsans_ace_tagger
//   Per-core AXI-to-ACE front stage feeding one CCU crossbar port.
//   Classifies every AR/AW against the shareable region and fills the ACE
//   snoop/domain/bar/awunique fields. The ACE fields on the input are ignored.
//   AR and AW pass through a one-entry register slice. The number of
//   outstanding read and write bursts is bounded. RACK/WACK are generated
//   from the R-last and B handshakes.
//
// Ports
//   clk_i       clock
//   rst_i       asynchronous active-high reset
//   slv_req_i   AXI request from the core
//   slv_resp_o  response to the core
//   mst_req_o   ACE request towards the CCU
//   mst_resp_i  response from the CCU
//   rack_o      one-cycle pulse after each R handshake with last
//   wack_o      one-cycle pulse after each B handshake
//   rd_busy_o   reads outstanding
//   wr_busy_o   writes outstanding

package culsans_pkg;

    typedef struct packed {
        logic [3:0]  id;
        logic [63:0] addr;
        logic [7:0]  len;
        logic [2:0]  size;
        logic [1:0]  burst;
        logic        lock;
        logic [3:0]  cache;
        logic [2:0]  prot;
        logic [3:0]  qos;
        logic [3:0]  region;
        logic [5:0]  atop;
        logic [2:0]  snoop;
        logic [1:0]  bar;
        logic [1:0]  domain;
        logic        awunique;
    } aw_chan_t;

    typedef struct packed {
        logic [63:0] data;
        logic [7:0]  strb;
        logic        last;
    } w_chan_t;

    typedef struct packed {
        logic [3:0] id;
        logic [1:0] resp;
    } b_chan_t;

    typedef struct packed {
        logic [3:0]  id;
        logic [63:0] addr;
        logic [7:0]  len;
        logic [2:0]  size;
        logic [1:0]  burst;
        logic        lock;
        logic [3:0]  cache;
        logic [2:0]  prot;
        logic [3:0]  qos;
        logic [3:0]  region;
        logic [3:0]  snoop;
        logic [1:0]  bar;
        logic [1:0]  domain;
    } ar_chan_t;

    typedef struct packed {
        logic [3:0]  id;
        logic [63:0] data;
        logic [3:0]  resp;
        logic        last;
    } r_chan_t;

    typedef struct packed {
        aw_chan_t aw;
        logic     aw_valid;
        w_chan_t  w;
        logic     w_valid;
        logic     b_ready;
        ar_chan_t ar;
        logic     ar_valid;
        logic     r_ready;
    } req_t;

    typedef struct packed {
        logic    aw_ready;
        logic    ar_ready;
        logic    w_ready;
        logic    b_valid;
        b_chan_t b;
        logic    r_valid;
        r_chan_t r;
    } resp_t;

endpackage

module culsans_ace_tagger #(
    parameter logic [63:0] SharedBase   = 64'h8004_0000,
    parameter logic [63:0] SharedLength = 64'h0004_0000,
    parameter int unsigned MaxReads     = 8,
    parameter int unsigned MaxWrites    = 8
) (
    input  logic               clk_i,
    input  logic               rst_i,
    input  culsans_pkg::req_t  slv_req_i,
    output culsans_pkg::resp_t slv_resp_o,
    output culsans_pkg::req_t  mst_req_o,
    input  culsans_pkg::resp_t mst_resp_i,
    output logic               rack_o,
    output logic               wack_o,
    output logic               rd_busy_o,
    output logic               wr_busy_o
);
    import culsans_pkg::*;

    localparam int unsigned RdCntW = $clog2(MaxReads + 1);
    localparam int unsigned WrCntW = $clog2(MaxWrites + 1);

    // The offset is taken modulo 2^64, so an address below the base wraps
    // high. That address is then rejected by the lower-bound term. The
    // region's upper bound therefore never wraps.
    function automatic logic in_shared(input logic [63:0] addr, input logic [3:0] cache);
        logic [63:0] offset;
        offset = addr - SharedBase;
        return (addr >= SharedBase) && (offset < SharedLength) && cache[1];
    endfunction

    // ---------------- classification ----------------
    ar_chan_t ar_in;
    aw_chan_t aw_in;

    always_comb begin
        ar_in     = slv_req_i.ar;
        ar_in.bar = '0;
        if (in_shared(slv_req_i.ar.addr, slv_req_i.ar.cache)) begin
            ar_in.snoop  = 4'b0001;
            ar_in.domain = 2'b01;
        end else begin
            ar_in.snoop  = 4'b0000;
            ar_in.domain = 2'b00;
        end
    end

    always_comb begin
        aw_in          = slv_req_i.aw;
        aw_in.bar      = '0;
        aw_in.awunique = 1'b0;
        aw_in.snoop    = 3'b000;
        // Atomics are never treated as shared.
        if (in_shared(slv_req_i.aw.addr, slv_req_i.aw.cache) && (slv_req_i.aw.atop == '0)) begin
            aw_in.domain = 2'b01;
        end else begin
            aw_in.domain = 2'b00;
        end
    end

    // ---------------- read side ----------------
    ar_chan_t          ar_q;
    logic              ar_full;
    logic [RdCntW-1:0] rd_cnt;
    logic              rd_stall;
    logic              ar_valid;
    logic              ar_hs;
    logic              ar_ready;
    logic              rd_done;

    // While the counter is saturated, the slice must not present its
    // entry. This holds even if a read retires in the same cycle. The
    // ready term sees the gated valid, so the slice keeps its entry.
    assign rd_stall = (rd_cnt == RdCntW'(MaxReads));
    assign ar_valid = ar_full && !rd_stall;
    assign ar_hs    = ar_valid && mst_resp_i.ar_ready;
    assign ar_ready = !ar_full || ar_hs;
    assign rd_done  = mst_resp_i.r_valid && slv_req_i.r_ready && mst_resp_i.r.last;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            ar_full <= 1'b0;
            ar_q    <= '0;
        end else if (slv_req_i.ar_valid && ar_ready) begin
            ar_full <= 1'b1;
            ar_q    <= ar_in;
        end else if (ar_hs) begin
            ar_full <= 1'b0;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            rd_cnt <= '0;
        end else if (ar_hs && !rd_done) begin
            rd_cnt <= rd_cnt + RdCntW'(1);
        end else if (!ar_hs && rd_done) begin
            rd_cnt <= rd_cnt - RdCntW'(1);
        end
    end

    // ---------------- write side ----------------
    aw_chan_t          aw_q;
    logic              aw_full;
    logic [WrCntW-1:0] wr_cnt;
    logic              wr_stall;
    logic              aw_valid;
    logic              aw_hs;
    logic              aw_ready;
    logic              wr_done;

    assign wr_stall = (wr_cnt == WrCntW'(MaxWrites));
    assign aw_valid = aw_full && !wr_stall;
    assign aw_hs    = aw_valid && mst_resp_i.aw_ready;
    assign aw_ready = !aw_full || aw_hs;
    assign wr_done  = mst_resp_i.b_valid && slv_req_i.b_ready;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            aw_full <= 1'b0;
            aw_q    <= '0;
        end else if (slv_req_i.aw_valid && aw_ready) begin
            aw_full <= 1'b1;
            aw_q    <= aw_in;
        end else if (aw_hs) begin
            aw_full <= 1'b0;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            wr_cnt <= '0;
        end else if (aw_hs && !wr_done) begin
            wr_cnt <= wr_cnt + WrCntW'(1);
        end else if (!aw_hs && wr_done) begin
            wr_cnt <= wr_cnt - WrCntW'(1);
        end
    end

    // ---------------- acknowledges ----------------
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            rack_o <= 1'b0;
            wack_o <= 1'b0;
        end else begin
            rack_o <= rd_done;
            wack_o <= wr_done;
        end
    end

    assign rd_busy_o = (rd_cnt != '0);
    assign wr_busy_o = (wr_cnt != '0);

    // ---------------- output assembly ----------------
    // W, B and R pass through combinationally. Only the AR/AW parts are
    // replaced by the registered slices.
    always_comb begin
        mst_req_o          = slv_req_i;
        mst_req_o.ar       = ar_q;
        mst_req_o.ar_valid = ar_valid;
        mst_req_o.aw       = aw_q;
        mst_req_o.aw_valid = aw_valid;

        slv_resp_o          = mst_resp_i;
        slv_resp_o.ar_ready = ar_ready;
        slv_resp_o.aw_ready = aw_ready;
    end

    // ---------------- counter sanity ----------------
    rd_overflow:  assert property (@(posedge clk_i) disable iff (rst_i)
                                   !(ar_hs && !rd_done && rd_stall));
    rd_underflow: assert property (@(posedge clk_i) disable iff (rst_i)
                                   !(rd_done && !ar_hs && (rd_cnt == '0)));
    wr_overflow:  assert property (@(posedge clk_i) disable iff (rst_i)
                                   !(aw_hs && !wr_done && wr_stall));
    wr_underflow: assert property (@(posedge clk_i) disable iff (rst_i)
                                   !(wr_done && !aw_hs && (wr_cnt == '0)));

endmodule
